// File: rtl/alu_issue.sv
// alu_issue: sequential issue/writeback controller for an 8-bit combinational ALU.
// Accepts one two-address instruction at a time, reads both operands from the
// register file, drives the ALU with registered command and operands, captures
// the result, writes it back and maintains the carry/zero/parity flags.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   in_valid/in_ready/in_instr   instruction handshake, [8:6] op [5:3] ra [2:0] rb
//   rf_raddr_a/b, rf_rdata_a/b   register file read (data returned same cycle)
//   rf_we, rf_waddr, rf_wdata    register file writeback
//   alu_cmd, alu_a, alu_b        registered ALU command and operands
//   alu_sc_i                     ALU carry in (mirrors carry_flag)
//   alu_rslt, alu_sc_o           ALU result and carry out
//   carry_flag/zero_flag/parity_flag  flag register
//   err                          one-cycle pulse on an illegal opcode
module alu_issue #(
    parameter int DW  = 8,
    parameter int RAW = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [8:0]     in_instr,
    output logic [RAW-1:0] rf_raddr_a,
    output logic [RAW-1:0] rf_raddr_b,
    input  logic [DW-1:0]  rf_rdata_a,
    input  logic [DW-1:0]  rf_rdata_b,
    output logic           rf_we,
    output logic [RAW-1:0] rf_waddr,
    output logic [DW-1:0]  rf_wdata,
    output logic [2:0]     alu_cmd,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic           alu_sc_i,
    input  logic [DW-1:0]  alu_rslt,
    input  logic           alu_sc_o,
    output logic           carry_flag,
    output logic           zero_flag,
    output logic           parity_flag,
    output logic           err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [2:0] OP_TSTZ = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_ROT  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b111;

    // Rotate amount is limited to the low three bits of the second operand.
    localparam logic [DW-1:0] ROT_MASK = DW'(7);

    logic [1:0]     state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [2:0]     ra_q, ra_d;
    logic [2:0]     rb_q, rb_d;
    logic [2:0]     cmd_q, cmd_d;
    logic [DW-1:0]  a_q, a_d;
    logic [DW-1:0]  b_q, b_d;
    logic [DW-1:0]  res_q, res_d;
    logic           cry_q, cry_d;
    logic [RAW-1:0] waddr_q, waddr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic           cf_q, cf_d;
    logic           zf_q, zf_d;
    logic           pf_q, pf_d;
    logic           err_q, err_d;

    logic [2:0] in_op;
    logic       in_legal;

    assign in_op    = in_instr[8:6];
    assign in_legal = (in_op == OP_TSTZ) || (in_op == OP_XOR) || (in_op == OP_ROT) ||
                      (in_op == OP_AND)  || (in_op == OP_ADD);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        cmd_d   = cmd_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cry_d   = cry_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cf_d    = cf_q;
        zf_d    = zf_q;
        pf_d    = pf_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Illegal ops are dropped without disturbing any held state.
                    if (in_legal) begin
                        op_d    = in_op;
                        ra_d    = in_instr[5:3];
                        rb_d    = in_instr[2:0];
                        state_d = S_READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                cmd_d   = op_q;
                a_d     = rf_rdata_a;
                b_d     = (op_q == OP_ROT) ? (rf_rdata_b & ROT_MASK) : rf_rdata_b;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d = alu_rslt;
                cry_d = alu_sc_o;
                // Write port registers double as the captured-result holding
                // registers; TSTZ leaves them at their last value.
                if (op_q != OP_TSTZ) begin
                    waddr_d = RAW'(ra_q);
                    wdata_d = alu_rslt;
                end
                state_d = S_WB;
            end
            default: begin
                if (op_q == OP_TSTZ) begin
                    zf_d = (a_q == '0);
                end else begin
                    zf_d = (res_q == '0);
                    pf_d = ^res_q;
                    if (op_q == OP_ADD) cf_d = cry_q;
                end
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            cmd_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cry_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
            pf_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cry_q   <= cry_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cf_q    <= cf_d;
            zf_q    <= zf_d;
            pf_q    <= pf_d;
            err_q   <= err_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign rf_raddr_a  = RAW'(ra_q);
    assign rf_raddr_b  = RAW'(rb_q);
    assign rf_we       = (state_q == S_WB) && (op_q != OP_TSTZ);
    assign rf_waddr    = waddr_q;
    assign rf_wdata    = wdata_q;
    assign alu_cmd     = cmd_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_sc_i    = cf_q;
    assign carry_flag  = cf_q;
    assign zero_flag   = zf_q;
    assign parity_flag = pf_q;
    assign err         = err_q;

endmodule
